tensor_seq: RTL and testbench

//  Sequencer for the 57715-word MLP parameter memory (W1/b1/W2/b2).
//  - Stays idle while the CPU loads parameters through its write port.
//  - On start, streams every parameter word once, in inference order, to the MAC datapath.
//  - The stream uses a valid/ready handshake with full backpressure.
//  - Sits between the CPU store path, the parameter memory and the MLP datapath.

---
 rtl/tensor_pkg.sv | 48 ++++
 rtl/tensor_obuf.sv | 61 ++++++
 rtl/tensor_seq.sv | 219 +++++++++++++++++++++
 tb/tb_tensor_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tensor_pkg.sv
// Shared constants, state encoding and stream tag layout for the MLP parameter sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tensor_pkg;

    localparam int DIM        = 57715;
    localparam int CPU_BASE   = 1036;
    localparam int OBUF_DEPTH = 2;

    localparam int W1_BASE = 0;
    localparam int B1_BASE = 57600;
    localparam int W2_BASE = 57664;
    localparam int B2_BASE = 57712;

    localparam int L1_ROWS = 64;
    localparam int L1_WPR  = 900;
    localparam int L2_ROWS = 3;
    localparam int L2_WPR  = 16;

    typedef enum logic {
        BIAS   = 1'b0,
        WEIGHT = 1'b1
    } kind_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1_BIAS,
        S_L1_W,
        S_L2_BIAS,
        S_L2_W,
        S_DRAIN
    } seq_state_e;

    typedef struct packed {
        kind_e      kind;
        logic       layer;
        logic [5:0] row;
        logic       last;
    } tag_t;

    typedef struct packed {
        tag_t        tag;
        logic [31:0] data;
    } obuf_ent_t;

    localparam int ENT_W = $bits(obuf_ent_t);

endpackage

// File: rtl/tensor_obuf.sv
// Small synchronous FIFO holding tagged read data ahead of the stream output.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: the caller must not push when full unless it pops in the same cycle.
module tensor_obuf #(
    parameter int DEPTH = 2,
    parameter int W     = 41,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [OW-1:0] occ
);

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [OW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != OW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (do_push) begin
                store[wr_ptr] <= push_dat;
                wr_ptr        <= nxt(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head = store[rd_ptr];
    assign occ  = cnt;

endmodule

// File: rtl/tensor_seq.sv
// Streams every MLP parameter word once, in inference order, and gates CPU parameter writes while idle.
// Latency: first mem_ren one cycle after start is sampled; read data reaches the stream head two edges later.
// Backpressure: o_valid/o_ready with full stall; reads are credit-limited so no word is ever dropped.
module tensor_seq
    import tensor_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        cpu_wen,
    input  logic [31:0] cpu_waddr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_wready,
    output logic        wr_err,
    output logic        mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        mem_ren,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [31:0] o_data,
    output logic        o_kind,
    output logic        o_layer,
    output logic [5:0]  o_row,
    output logic        o_last
);

    localparam int OCC_W = $clog2(OBUF_DEPTH + 1);

    seq_state_e        state_q, state_d;
    logic [5:0]        row_q, row_d;
    logic [9:0]        k_q, k_d;
    logic [31:0]       wptr_q, wptr_d;
    logic              inflight_q;
    tag_t              tag_q;
    logic              done_q, done_d;
    logic              wr_err_q;

    logic              rd_en;
    logic [31:0]       rd_addr;
    tag_t              rd_tag;
    logic              pop;
    logic              credit_ok;
    logic              drained;
    logic              in_win;
    logic              wr_drop;
    logic [OCC_W-1:0]  occ;
    obuf_ent_t         head;
    obuf_ent_t         push_ent;

    assign busy = (state_q != S_IDLE);
    assign pop  = o_valid & o_ready;

    // A read may issue only if its word is guaranteed a buffer slot when it lands.
    assign credit_ok = (int'(occ) + int'(inflight_q) - int'(pop)) < OBUF_DEPTH;
    assign drained   = ~inflight_q && (int'(occ) == int'(pop));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        k_d     = k_q;
        wptr_d  = wptr_q;
        done_d  = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        rd_tag  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_L1_BIAS;
                    row_d   = '0;
                    k_d     = '0;
                    wptr_d  = 32'(W1_BASE);
                end
            end
            S_L1_BIAS: begin
                rd_en       = credit_ok;
                rd_addr     = 32'(B1_BASE) + 32'(row_q);
                rd_tag.kind = BIAS;
                rd_tag.row  = row_q;
                if (rd_en) begin
                    state_d = S_L1_W;
                end
            end
            S_L1_W: begin
                rd_en       = credit_ok;
                rd_addr     = wptr_q;
                rd_tag.kind = WEIGHT;
                rd_tag.row  = row_q;
                rd_tag.last = (k_q == 10'(L1_WPR - 1));
                if (rd_en) begin
                    wptr_d = wptr_q + 32'd1;
                    if (rd_tag.last) begin
                        k_d = '0;
                        if (row_q == 6'(L1_ROWS - 1)) begin
                            row_d   = '0;
                            wptr_d  = 32'(W2_BASE);
                            state_d = S_L2_BIAS;
                        end else begin
                            row_d   = row_q + 6'd1;
                            state_d = S_L1_BIAS;
                        end
                    end else begin
                        k_d = k_q + 10'd1;
                    end
                end
            end
            S_L2_BIAS: begin
                rd_en        = credit_ok;
                rd_addr      = 32'(B2_BASE) + 32'(row_q);
                rd_tag.kind  = BIAS;
                rd_tag.layer = 1'b1;
                rd_tag.row   = row_q;
                if (rd_en) begin
                    state_d = S_L2_W;
                end
            end
            S_L2_W: begin
                rd_en        = credit_ok;
                rd_addr      = wptr_q;
                rd_tag.kind  = WEIGHT;
                rd_tag.layer = 1'b1;
                rd_tag.row   = row_q;
                rd_tag.last  = (k_q == 10'(L2_WPR - 1));
                if (rd_en) begin
                    wptr_d = wptr_q + 32'd1;
                    if (rd_tag.last) begin
                        k_d = '0;
                        if (row_q == 6'(L2_ROWS - 1)) begin
                            state_d = S_DRAIN;
                        end else begin
                            row_d   = row_q + 6'd1;
                            state_d = S_L2_BIAS;
                        end
                    end else begin
                        k_d = k_q + 10'd1;
                    end
                end
            end
            S_DRAIN: begin
                // Leave on the edge of the final handshake so done lands one cycle after it.
                if (drained) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            k_q        <= '0;
            wptr_q     <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            done_q     <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            k_q        <= k_d;
            wptr_q     <= wptr_d;
            inflight_q <= rd_en;
            if (rd_en) begin
                tag_q <= rd_tag;
            end
            done_q     <= done_d;
            wr_err_q   <= wr_drop;
        end
    end

    assign push_ent.tag  = tag_q;
    assign push_ent.data = mem_rdata;

    tensor_obuf #(
        .DEPTH (OBUF_DEPTH),
        .W     (ENT_W)
    ) u_obuf (
        .clk      (clk),
        .rst      (rst),
        .flush    (~busy & start),
        .push     (inflight_q),
        .push_dat (push_ent),
        .pop      (pop),
        .head     (head),
        .occ      (occ)
    );

    assign o_valid = (occ != '0);
    assign o_data  = head.data;
    assign o_kind  = head.tag.kind;
    assign o_layer = head.tag.layer;
    assign o_row   = head.tag.row;
    assign o_last  = head.tag.last;

    assign mem_ren  = rd_en;
    assign mem_addr = rd_addr;

    // Writes only land while idle, so the memory port never sees a read and write together.
    assign in_win     = (cpu_waddr >= 32'(CPU_BASE)) && (cpu_waddr < 32'(CPU_BASE + DIM));
    assign cpu_wready = ~rst & ~busy;
    assign mem_wen    = cpu_wen & cpu_wready & in_win;
    assign wr_drop    = cpu_wen & cpu_wready & ~in_win;
    assign mem_waddr  = mem_wen ? (cpu_waddr - 32'(CPU_BASE)) : '0;
    assign mem_wdata  = mem_wen ? cpu_wdata : '0;

    assign done   = done_q;
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_tensor_seq.sv
// Bench for tensor_seq: memory model plus expected stream built from the parameter layout.
module tb_tensor_seq;

    localparam int N = 57715;

    logic        clk = 1'b0;
    logic        rst, start, busy, done;
    logic        cpu_wen, cpu_wready, wr_err;
    logic [31:0] cpu_waddr, cpu_wdata;
    logic        mem_wen, mem_ren;
    logic [31:0] mem_waddr, mem_wdata, mem_addr, mem_rdata;
    logic        o_valid, o_ready, o_kind, o_layer, o_last;
    logic [31:0] o_data;
    logic [5:0]  o_row;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tensor_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .cpu_wen    (cpu_wen),
        .cpu_waddr  (cpu_waddr),
        .cpu_wdata  (cpu_wdata),
        .cpu_wready (cpu_wready),
        .wr_err     (wr_err),
        .mem_wen    (mem_wen),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_ren    (mem_ren),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_kind     (o_kind),
        .o_layer    (o_layer),
        .o_row      (o_row),
        .o_last     (o_last)
    );

    // Memory contents: unwritten words hold a seeded hash of their address.
    logic [31:0] seed;
    logic [31:0] mem_d  [N];
    bit          mem_f  [N];
    logic [31:0] ref_w  [int unsigned];
    int unsigned rd_log [$];
    int          collisions = 0;

    int unsigned exp_addr [N];
    logic [8:0]  exp_tag  [N];

    function automatic logic [31:0] pat(input int unsigned a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic logic [31:0] exp_data(input int unsigned a);
        return ref_w.exists(a) ? ref_w[a] : pat(a);
    endfunction

    always @(posedge clk) begin
        if (mem_wen && mem_ren) collisions <= collisions + 1;
        if (mem_wen && mem_waddr < N) begin
            mem_d[mem_waddr] <= mem_wdata;
            mem_f[mem_waddr] <= 1'b1;
        end
        if (mem_ren) begin
            mem_rdata <= (mem_addr < N) ? (mem_f[mem_addr] ? mem_d[mem_addr] : pat(mem_addr)) : 32'hDEAD_BEEF;
            rd_log.push_back(mem_addr);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input bit good);
        cpu_wen = 1'b1; cpu_waddr = a; cpu_wdata = d;
        #1;
        check("wr_wready", cpu_wready, 1'b1);
        check("wr_wen", mem_wen, good);
        if (good) begin
            check("wr_waddr", mem_waddr, a - 32'd1036);
            check("wr_wdata", mem_wdata, d);
            ref_w[a - 32'd1036] = d;
        end
        @(negedge clk);
        cpu_wen = 1'b0;
        check("wr_err_pulse", wr_err, !good);
        @(negedge clk);
        check("wr_err_clear", wr_err, 1'b0);
    endtask

    // Runs one pass from the cycle after start is driven until stop_at words have handshaked.
    // mode 0: o_ready held high, busy write probe; mode 1: random o_ready windows, start re-probe.
    task automatic run_pass(input int mode, input int stop_at);
        int idx = 0, cyc = 0, first_valid = 0, bubbles = 0, done_seen = 0;
        bit seen_valid = 0, prev_stall = 0;
        logic [40:0] cur, prev;
        prev = '0;
        while (idx < stop_at && cyc < 75000) begin
            @(negedge clk);
            cyc++;
            cur = {o_kind, o_layer, o_row, o_last, o_data};
            if (cyc == 1) begin
                start = 1'b0; cpu_wen = 1'b0;
                check("busy_rise", busy, 1'b1);
                check("first_ren", mem_ren, 1'b1);
            end
            if (prev_stall) check("stall_hold", {o_valid, cur}, {1'b1, prev});
            if (o_valid) begin
                if (!seen_valid) first_valid = cyc;
                seen_valid = 1;
            end else if (seen_valid) begin
                bubbles++;
            end
            if (done) done_seen++;
            if (mode == 0 && cyc == 50) begin
                cpu_wen = 1'b1; cpu_waddr = 32'd1100; cpu_wdata = 32'h1234;
                #1;
                check("busy_wready", cpu_wready, 1'b0);
                check("busy_wen", mem_wen, 1'b0);
            end
            if (mode == 0 && cyc == 51) cpu_wen = 1'b0;
            if (mode == 1 && cyc == 5000) start = 1'b1;
            if (mode == 1 && cyc == 5001) start = 1'b0;
            if (mode == 1 && (idx < 1000 || idx > N - 400 || (idx > 57600 && idx < 57700)))
                o_ready = 1'($urandom_range(0, 1));
            else
                o_ready = 1'b1;
            if (o_valid && o_ready) begin
                check("word", cur, {exp_tag[idx], exp_data(exp_addr[idx])});
                if (idx == 0)     check("first_b1_row0", o_data, exp_data(57600));
                if (idx == 1)     check("w1_row0_k0", cur, {9'b1_0_000000_0, 32'hA5A5_0001});
                if (idx == 2)     check("start_write_word", o_data, 32'h0BAD_F00D);
                if (idx == 57663) check("l1_row63_last", {o_last, o_layer, o_row}, {1'b1, 1'b0, 6'd63});
                if (idx == 57664) check("l2_bias0", {o_kind, o_layer, o_row, o_last}, {1'b0, 1'b1, 6'd0, 1'b0});
                if (idx == 57698) check("b2_row2_data", o_data, 32'h7);
                idx++;
            end
            prev_stall = o_valid && !o_ready;
            prev = cur;
        end
        check("pass_words", idx, stop_at);
        check("first_valid_cycle", first_valid, 3);
        check("no_bubbles", bubbles, 0);
        check("no_early_done", done_seen, 0);
    endtask

    initial begin
        int idx;
        int base;
        int abort_done;
        seed = $urandom;
        idx = 0;
        for (int r = 0; r < 64; r++) begin
            exp_addr[idx] = 57600 + r; exp_tag[idx] = {1'b0, 1'b0, 6'(r), 1'b0}; idx++;
            for (int k = 0; k < 900; k++) begin
                exp_addr[idx] = r * 900 + k; exp_tag[idx] = {1'b1, 1'b0, 6'(r), k == 899}; idx++;
            end
        end
        for (int r = 0; r < 3; r++) begin
            exp_addr[idx] = 57712 + r; exp_tag[idx] = {1'b0, 1'b1, 6'(r), 1'b0}; idx++;
            for (int k = 0; k < 16; k++) begin
                exp_addr[idx] = 57664 + r * 16 + k; exp_tag[idx] = {1'b1, 1'b1, 6'(r), k == 15}; idx++;
            end
        end

        rst = 1'b1; start = 1'b0; cpu_wen = 1'b0; cpu_waddr = '0; cpu_wdata = '0; o_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {busy, done, cpu_wready, o_valid, mem_wen, mem_ren, wr_err}, 7'b0);
        rst = 1'b0;
        @(negedge clk);
        check("wready_after_rst", {cpu_wready, busy}, 2'b10);

        cpu_write(32'd1036,  32'hA5A5_0001, 1'b1);
        cpu_write(32'd58750, 32'h0000_0007, 1'b1);
        cpu_write(32'd1035,  32'h1111_1111, 1'b0);
        cpu_write(32'd58751, 32'h2222_2222, 1'b0);

        // Pass A: start and a write in the same idle cycle, then reset partway through.
        o_ready = 1'b1;
        start = 1'b1; cpu_wen = 1'b1; cpu_waddr = 32'd1037; cpu_wdata = 32'h0BAD_F00D;
        #1;
        check("start_cycle_wen", mem_wen, 1'b1);
        check("start_cycle_ren", mem_ren, 1'b0);
        ref_w[1] = 32'h0BAD_F00D;
        run_pass(0, 3000);
        rst = 1'b1;
        @(negedge clk);
        check("abort_state", {o_valid, busy, done, mem_ren}, 4'b0);
        rst = 1'b0;
        abort_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy || o_valid) abort_done++;
        end
        check("abort_quiet", abort_done, 0);

        // Pass B: full pass with random stalls and a start while busy.
        base = rd_log.size();
        start = 1'b1;
        run_pass(1, N);
        @(negedge clk);
        check("done_pulse", {done, busy}, 2'b10);
        @(negedge clk);
        check("done_clear", {done, busy, cpu_wready}, 3'b001);
        check("read_count", rd_log.size() - base, N);
        for (int i = 0; i < N; i++) begin
            if (base + i < rd_log.size()) check("rd_addr", rd_log[base + i], exp_addr[i]);
        end
        check("no_rw_collision", collisions, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
